// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression of one 512-bit block, UNROLL rounds per clock.
// The message schedule lives in a sliding 16-word window; the digest is registered.
module sha256_round_engine #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] hash_in,
  output logic         ready,
  output logic         busy,
  output logic         valid,
  output logic [255:0] digest
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha256_round_engine: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [5:0] Step  = 6'(UNROLL);
  localparam logic [5:0] LastT = 6'(64 - UNROLL);

  localparam logic [31:0] KRom [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  state_e       state_q;
  logic [5:0]   t_q;
  logic [31:0]  w_q  [16];
  logic [31:0]  wv_q [8];
  logic [31:0]  hs_q [8];
  logic [255:0] digest_q;
  logic         valid_q;

  logic [31:0]  w_d  [16];
  logic [31:0]  wv_d [8];
  logic [255:0] digest_d;

  // Chain UNROLL rounds; ext holds W[t..t+15+UNROLL] so the window can slide.
  always_comb begin
    logic [31:0] ext [16 + UNROLL];
    logic [31:0] wv  [8];
    logic [31:0] t1, t2;
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int k = 0; k < int'(UNROLL); k++) begin
      ext[16 + k] = ssig1(ext[14 + k]) + ext[9 + k] + ssig0(ext[1 + k]) + ext[k];
    end
    for (int i = 0; i < 8; i++) wv[i] = wv_q[i];
    for (int u = 0; u < int'(UNROLL); u++) begin
      t1 = wv[7] + bsig1(wv[4]) + ch(wv[4], wv[5], wv[6]) + KRom[t_q + 6'(u)] + ext[u];
      t2 = bsig0(wv[0]) + maj(wv[0], wv[1], wv[2]);
      wv[7] = wv[6];
      wv[6] = wv[5];
      wv[5] = wv[4];
      wv[4] = wv[3] + t1;
      wv[3] = wv[2];
      wv[2] = wv[1];
      wv[1] = wv[0];
      wv[0] = t1 + t2;
    end
    for (int i = 0; i < 16; i++) w_d[i] = ext[i + int'(UNROLL)];
    for (int i = 0; i < 8; i++) wv_d[i] = wv[i];
  end

  always_comb begin
    digest_d = '0;
    for (int i = 0; i < 8; i++) digest_d[255 - 32*i -: 32] = hs_q[i] + wv_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      t_q      <= '0;
      digest_q <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        wv_q[i] <= '0;
        hs_q[i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            for (int i = 0; i < 16; i++) w_q[i] <= block_in[511 - 32*i -: 32];
            for (int i = 0; i < 8; i++) begin
              wv_q[i] <= hash_in[255 - 32*i -: 32];
              hs_q[i] <= hash_in[255 - 32*i -: 32];
            end
            t_q     <= '0;
            state_q <= StRound;
          end
        end
        StRound: begin
          for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
          for (int i = 0; i < 8; i++) wv_q[i] <= wv_d[i];
          t_q <= t_q + Step;
          if (t_q == LastT) state_q <= StDone;
        end
        StDone: begin
          digest_q <= digest_d;
          valid_q  <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready  = (state_q == StIdle);
  assign busy   = (state_q != StIdle);
  assign valid  = valid_q;
  assign digest = digest_q;

endmodule
